stream_demux_1to2: RTL and testbench



---
 rtl/stream_demux_1to2_if.sv | 27 ++
 rtl/stream_demux_1to2.sv | 93 +++++++++
 tb/tb_stream_demux_1to2.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for the 1-to-2 stream demux: one input stream plus two output channels.
// slave is the demux view, master is the upstream/downstream environment view.
interface stream_demux_1to2_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_sel;
  logic             in_ready;
  logic [WIDTH-1:0] y0_data;
  logic             y0_valid;
  logic             y0_last;
  logic             y0_ready;
  logic [WIDTH-1:0] y1_data;
  logic             y1_valid;
  logic             y1_last;
  logic             y1_ready;

  modport slave (
    input  in_data, in_valid, in_last, in_sel, y0_ready, y1_ready,
    output in_ready, y0_data, y0_valid, y0_last, y1_data, y1_valid, y1_last
  );

  modport master (
    output in_data, in_valid, in_last, in_sel, y0_ready, y1_ready,
    input  in_ready, y0_data, y0_valid, y0_last, y1_data, y1_valid, y1_last
  );
endinterface

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux with per-packet select locking and a one-entry register per channel.
// Optional STREAM_DEMUX_STATS_EN adds saturating per-channel completed-packet counters.
module stream_demux_1to2 #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  stream_demux_1to2_if.slave bus,
  output logic busy
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0] y0_pkts,
  output logic [15:0] y1_pkts
`endif
);
  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                 state;
  logic                   route_sel;
  logic [1:0][WIDTH-1:0]  dat;
  logic [1:0]             vld;
  logic [1:0]             lst;
  logic [1:0]             rdy;
  logic [1:0]             drain;
  logic [1:0]             load;
  logic                   act_sel;
  logic                   accept;

  assign rdy     = {bus.y1_ready, bus.y0_ready};
  assign drain   = vld & rdy;
  assign act_sel = (state == ROUTE) ? route_sel : bus.in_sel;

  // Target register may take a beat when empty or when it empties this same cycle.
  assign bus.in_ready = rst_n && (!vld[act_sel] || drain[act_sel]);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept ? (act_sel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      route_sel <= 1'b0;
      dat       <= '0;
      vld       <= '0;
      lst       <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (load[c]) begin
          dat[c] <= bus.in_data;
          lst[c] <= bus.in_last;
          vld[c] <= 1'b1;
        end else if (drain[c]) begin
          dat[c] <= '0;
          lst[c] <= 1'b0;
          vld[c] <= 1'b0;
        end
      end
      if (accept) begin
        case (state)
          IDLE: if (!bus.in_last) begin
            route_sel <= bus.in_sel;
            state     <= ROUTE;
          end
          ROUTE: if (bus.in_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.y0_data  = dat[0];
  assign bus.y0_valid = vld[0];
  assign bus.y0_last  = lst[0];
  assign bus.y1_data  = dat[1];
  assign bus.y1_valid = vld[1];
  assign bus.y1_last  = lst[1];
  assign busy         = (state == ROUTE) || (|vld);

`ifdef STREAM_DEMUX_STATS_EN
  logic [1:0][15:0] pkts;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkts <= '0;
    end else begin
      for (int c = 0; c < 2; c++)
        if (drain[c] && lst[c] && pkts[c] != 16'hFFFF) pkts[c] <= pkts[c] + 16'd1;
    end
  end

  assign y0_pkts = pkts[0];
  assign y1_pkts = pkts[1];
`endif
endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed vector table, randomized run against a packet-level model,
// and counter checks when STREAM_DEMUX_STATS_EN is defined.
module tb_stream_demux_1to2;
  logic clk;
  logic rst_n;
  logic busy;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] y0_pkts;
  logic [15:0] y1_pkts;
`endif

  stream_demux_1to2_if #(.WIDTH(8)) bus ();

  stream_demux_1to2 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .y0_pkts (y0_pkts),
    .y1_pkts (y1_pkts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         r, v;
    logic [7:0] d;
    bit         l, s, r0, r1;
    bit         e_rdy, e_v0;
    logic [7:0] e_d0;
    bit         e_l0, e_v1;
    logic [7:0] e_d1;
    bit         e_l1, e_busy;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit l, input bit s,
                       input bit r0, input bit r1);
    rst_n        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_sel   = s;
    bus.y0_ready = r0;
    bus.y1_ready = r1;
  endtask

  // Model of the stream: open packet's channel (-1 when none) and each channel's held beat.
  int         open_ch;
  bit         mv[2];
  logic [7:0] md[2];
  bit         ml[2];

  task automatic model_reset();
    open_ch = -1;
    for (int c = 0; c < 2; c++) begin mv[c] = 0; md[c] = '0; ml[c] = 0; end
  endtask

  vec_t tbl[18];

  initial begin
    drive(0, 0, 8'h00, 0, 0, 1, 1);

    // r v data l s r0 r1 | rdy v0 d0 l0 v1 d1 l1 busy
    tbl[0]  = '{0,0,8'h00,0,0,1,1, 0, 0,8'h00,0, 0,8'h00,0, 0};
    tbl[1]  = '{1,0,8'h00,0,0,1,1, 1, 0,8'h00,0, 0,8'h00,0, 0};
    tbl[2]  = '{1,1,8'hA5,1,0,1,1, 1, 1,8'hA5,1, 0,8'h00,0, 1};
    tbl[3]  = '{1,1,8'h3C,1,1,1,1, 1, 0,8'h00,0, 1,8'h3C,1, 1};
    tbl[4]  = '{1,1,8'h11,0,1,1,1, 1, 0,8'h00,0, 1,8'h11,0, 1};
    tbl[5]  = '{1,1,8'h22,0,0,1,1, 1, 0,8'h00,0, 1,8'h22,0, 1};
    tbl[6]  = '{1,1,8'h33,1,0,1,1, 1, 0,8'h00,0, 1,8'h33,1, 1};
    tbl[7]  = '{1,0,8'h00,0,0,1,1, 1, 0,8'h00,0, 0,8'h00,0, 0};
    tbl[8]  = '{1,1,8'h55,1,0,0,1, 1, 1,8'h55,1, 0,8'h00,0, 1};
    tbl[9]  = '{1,1,8'h77,1,0,0,1, 0, 1,8'h55,1, 0,8'h00,0, 1};
    tbl[10] = '{1,1,8'h66,1,1,0,1, 1, 1,8'h55,1, 1,8'h66,1, 1};
    tbl[11] = '{1,1,8'h77,1,0,1,1, 1, 1,8'h77,1, 0,8'h00,0, 1};
    tbl[12] = '{1,0,8'h00,0,0,1,1, 1, 0,8'h00,0, 0,8'h00,0, 0};
    tbl[13] = '{1,1,8'hA1,0,1,1,1, 1, 0,8'h00,0, 1,8'hA1,0, 1};
    tbl[14] = '{1,1,8'hA2,0,0,1,1, 1, 0,8'h00,0, 1,8'hA2,0, 1};
    tbl[15] = '{0,1,8'hA3,0,1,1,1, 0, 0,8'h00,0, 0,8'h00,0, 0};
    tbl[16] = '{1,1,8'hB7,1,0,1,1, 1, 1,8'hB7,1, 0,8'h00,0, 1};
    tbl[17] = '{1,0,8'h00,0,0,1,1, 1, 0,8'h00,0, 0,8'h00,0, 0};

    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d y0_valid", i), 32'(bus.y0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("tbl%0d y0_data", i),  32'(bus.y0_data),  32'(tbl[i].e_d0));
      chk($sformatf("tbl%0d y0_last", i),  32'(bus.y0_last),  32'(tbl[i].e_l0));
      chk($sformatf("tbl%0d y1_valid", i), 32'(bus.y1_valid), 32'(tbl[i].e_v1));
      chk($sformatf("tbl%0d y1_data", i),  32'(bus.y1_data),  32'(tbl[i].e_d1));
      chk($sformatf("tbl%0d y1_last", i),  32'(bus.y1_last),  32'(tbl[i].e_l1));
      chk($sformatf("tbl%0d busy", i),     32'(busy),         32'(tbl[i].e_busy));
    end

    // Randomized traffic; occasional resets exercise mid-packet discard.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit         r, v, l, s, r0, r1, exp_rdy, acc;
      logic [7:0] d;
      int         tgt;
      bit         drained[2];
      @(negedge clk);
      r  = ($urandom_range(0, 39) != 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      l  = ($urandom_range(0, 2) == 0);
      s  = 1'($urandom);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      drive(r, v, d, l, s, r0, r1);
      tgt     = (open_ch >= 0) ? open_ch : int'(s);
      exp_rdy = r && (!mv[tgt] || (tgt == 0 ? r0 : r1));
      acc     = v && exp_rdy;
      #1;
      chk($sformatf("rnd%0d in_ready", n), 32'(bus.in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (!r) begin
        model_reset();
      end else begin
        drained[0] = mv[0] && r0;
        drained[1] = mv[1] && r1;
        for (int c = 0; c < 2; c++) begin
          if (acc && tgt == c) begin
            mv[c] = 1; md[c] = d; ml[c] = l;
          end else if (drained[c]) begin
            mv[c] = 0; md[c] = '0; ml[c] = 0;
          end
        end
        if (acc) open_ch = l ? -1 : tgt;
      end
      #1;
      chk($sformatf("rnd%0d y0_valid", n), 32'(bus.y0_valid), 32'(mv[0]));
      chk($sformatf("rnd%0d y0_data", n),  32'(bus.y0_data),  32'(md[0]));
      chk($sformatf("rnd%0d y0_last", n),  32'(bus.y0_last),  32'(ml[0]));
      chk($sformatf("rnd%0d y1_valid", n), 32'(bus.y1_valid), 32'(mv[1]));
      chk($sformatf("rnd%0d y1_data", n),  32'(bus.y1_data),  32'(md[1]));
      chk($sformatf("rnd%0d y1_last", n),  32'(bus.y1_last),  32'(ml[1]));
      chk($sformatf("rnd%0d busy", n),     32'(busy), 32'((open_ch >= 0) || mv[0] || mv[1]));
    end

`ifdef STREAM_DEMUX_STATS_EN
    begin
      logic [7:0] pk_d[7];
      bit         pk_l[7];
      bit         pk_s[7];
      pk_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      pk_l = '{1, 0, 1, 1, 0, 0, 1};
      pk_s = '{0, 0, 0, 0, 1, 0, 0};
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 1, 1);
      @(posedge clk);
      #1;
      chk("pkts reset y0", 32'(y0_pkts), 32'd0);
      chk("pkts reset y1", 32'(y1_pkts), 32'd0);
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        drive(1, 1, pk_d[i], pk_l[i], pk_s[i], 1, 1);
      end
      @(negedge clk);
      drive(1, 0, 8'h00, 0, 0, 1, 1);
      @(negedge clk);
      chk("pkts y0", 32'(y0_pkts), 32'd3);
      chk("pkts y1", 32'(y1_pkts), 32'd1);
      for (int i = 0; i < 65535; i++) begin
        @(negedge clk);
        drive(1, 1, 8'hEE, 1, 0, 1, 1);
      end
      @(negedge clk);
      drive(1, 0, 8'h00, 0, 0, 1, 1);
      @(negedge clk);
      chk("pkts y0 saturate", 32'(y0_pkts), 32'hFFFF);
      chk("pkts y1 untouched", 32'(y1_pkts), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
